core_redirect_ctrl: RTL and testbench

CORE_REDIRECT_CTRL -- requirements
Module: core_redirect_ctrl

---
 rtl/core_redirect_ctrl_pkg.sv | 14 +
 rtl/core_redirect_ctrl.sv | 111 +++++++++++
 tb/tb_core_redirect_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/core_redirect_ctrl_pkg.sv
// Shared pipeline definitions for the frontend redirect path:
// redirect FSM encoding, drain-counter width and the default drain length.
package core_redirect_ctrl_pkg;

  localparam int unsigned REDIRECT_FLUSH_CYCLES = 2;
  localparam int unsigned DRAIN_CNT_W           = $clog2(16);

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_DRAIN = 2'd1,
    RS_REDIR = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/core_redirect_ctrl.sv
// Redirect controller: arbitrates exception and branch-mispredict redirects,
// pulses a backend flush, waits out the drain window, then offers the PC to the frontend.
module core_redirect_ctrl
  import core_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = REDIRECT_FLUSH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_trigger_i,
  input  logic [31:0] excp_target_i,
  input  logic        br_miss_i,
  input  logic [31:0] br_target_i,
  input  logic        fe_ready_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o,
  output logic [15:0] excp_cnt_o
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(FLUSH_CYCLES - 1);

  redirect_state_e        state_r;
  logic [DRAIN_CNT_W-1:0] cnt_r;
  logic [31:0]            target_r;
  logic                   flush_r;
  logic                   valid_r;
  logic                   busy_r;
  logic [15:0]            excp_cnt_r;
  logic                   accept_s;
  logic [31:0]            next_target_s;

  // Event arbitration: exceptions win everywhere, branch misses only count while idle.
  always_comb begin
    accept_s      = 1'b0;
    next_target_s = target_r;
    if (excp_trigger_i) begin
      accept_s      = 1'b1;
      next_target_s = excp_target_i;
    end else if (br_miss_i && (state_r == RS_IDLE)) begin
      accept_s      = 1'b1;
      next_target_s = br_target_i;
    end else begin
      accept_s      = 1'b0;
      next_target_s = target_r;
    end
  end

  // Redirect FSM with registered flush/valid/busy and the exception counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RS_IDLE;
      cnt_r      <= '0;
      target_r   <= 32'h0000_0000;
      flush_r    <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      excp_cnt_r <= 16'h0000;
    end else begin
      flush_r <= 1'b0;
      if (accept_s) begin
        // A new event always restarts the drain, even over a redirect being offered.
        state_r  <= RS_DRAIN;
        cnt_r    <= DRAIN_LOAD;
        target_r <= next_target_s;
        flush_r  <= 1'b1;
        valid_r  <= 1'b0;
        busy_r   <= 1'b1;
        if (excp_trigger_i) begin
          excp_cnt_r <= excp_cnt_r + 16'd1;
        end
      end else begin
        case (state_r)
          RS_IDLE: begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
          RS_DRAIN: begin
            if (cnt_r == '0) begin
              state_r <= RS_REDIR;
              valid_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r - 1'b1;
            end
          end
          RS_REDIR: begin
            if (fe_ready_i) begin
              state_r <= RS_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= RS_IDLE;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign flush_o          = flush_r;
  assign redirect_valid_o = valid_r;
  assign redirect_pc_o    = target_r;
  assign busy_o           = busy_r;
  assign excp_cnt_o       = excp_cnt_r;

endmodule

// File: tb/tb_core_redirect_ctrl.sv
// Self-checking bench for core_redirect_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a timeline model.
module tb_core_redirect_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_trigger_i;
  logic [31:0] excp_target_i;
  logic        br_miss_i;
  logic [31:0] br_target_i;
  logic        fe_ready_i;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;
  logic [15:0] excp_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit preload_now = 1'b0;

  // Model: a redirect is "pending" from its accepting edge until the frontend
  // takes it; age counts edges since acceptance (saturating at FC).
  bit          m_pending = 1'b0;
  int          m_age     = 0;
  logic [31:0] m_tgt     = 32'h0;
  logic [15:0] m_cnt     = 16'h0;

  core_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk              (clk),
    .rst              (rst),
    .excp_trigger_i   (excp_trigger_i),
    .excp_target_i    (excp_target_i),
    .br_miss_i        (br_miss_i),
    .br_target_i      (br_target_i),
    .fe_ready_i       (fe_ready_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o),
    .excp_cnt_o       (excp_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    excp_trigger_i = 1'b0;
    br_miss_i      = 1'b0;
    excp_target_i  = 32'h0;
    br_target_i    = 32'h0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pending = 1'b0;
      m_age     = 0;
      m_tgt     = 32'h0;
      m_cnt     = 16'h0;
    end else begin
      if (preload_now) m_cnt = 16'hFFFF;
      if (excp_trigger_i || (!m_pending && br_miss_i)) begin
        m_tgt     = excp_trigger_i ? excp_target_i : br_target_i;
        m_cnt     = m_cnt + (excp_trigger_i ? 16'd1 : 16'd0);
        m_pending = 1'b1;
        m_age     = 0;
      end else if (m_pending) begin
        if (m_age == FC) begin
          if (fe_ready_i) m_pending = 1'b0;
        end else begin
          m_age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_flush", {31'h0, flush_o}, {31'h0, (m_pending && m_age == 0)});
      check("model_valid", {31'h0, redirect_valid_o}, {31'h0, (m_pending && m_age == FC)});
      check("model_busy",  {31'h0, busy_o}, {31'h0, m_pending});
      check("model_pc",    redirect_pc_o, m_tgt);
      check("model_cnt",   {16'h0, excp_cnt_o}, {16'h0, m_cnt});
    end
  end

  initial begin
    rst = 1'b1;
    fe_ready_i = 1'b0;
    idle_inputs();
    step();
    step();
    chk_en = 1'b1;
    check("reset_valid", {31'h0, redirect_valid_o}, 32'h0);
    check("reset_busy",  {31'h0, busy_o}, 32'h0);
    check("reset_pc",    redirect_pc_o, 32'h0);
    check("reset_cnt",   {16'h0, excp_cnt_o}, 32'h0);
    rst = 1'b0;

    // Branch miss from idle, frontend always ready
    br_miss_i = 1'b1; br_target_i = 32'h1C00_0100; fe_ready_i = 1'b1;
    step();
    check("br_flush_t1", {31'h0, flush_o}, 32'h1);
    check("br_busy_t1",  {31'h0, busy_o}, 32'h1);
    idle_inputs();
    step();
    check("br_flush_t2", {31'h0, flush_o}, 32'h0);
    check("br_valid_t2", {31'h0, redirect_valid_o}, 32'h0);
    step();
    check("br_valid_t3", {31'h0, redirect_valid_o}, 32'h1);
    check("br_pc_t3",    redirect_pc_o, 32'h1C00_0100);
    step();
    check("br_idle_t4",  {31'h0, busy_o}, 32'h0);
    check("br_valid_t4", {31'h0, redirect_valid_o}, 32'h0);

    // Simultaneous exception and branch miss: exception wins
    fe_ready_i = 1'b0;
    excp_trigger_i = 1'b1; excp_target_i = 32'h1C00_8000;
    br_miss_i = 1'b1;      br_target_i   = 32'h1C00_0200;
    step();
    check("both_cnt", {16'h0, excp_cnt_o}, 32'h1);
    idle_inputs();
    step();
    step();
    check("both_valid", {31'h0, redirect_valid_o}, 32'h1);
    check("both_pc",    redirect_pc_o, 32'h1C00_8000);

    // Frontend stalls five cycles in REDIR
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'h0, redirect_valid_o}, 32'h1);
      check("stall_pc",    redirect_pc_o, 32'h1C00_8000);
    end
    fe_ready_i = 1'b1;
    step();
    check("stall_taken_valid", {31'h0, redirect_valid_o}, 32'h0);
    check("stall_taken_busy",  {31'h0, busy_o}, 32'h0);
    fe_ready_i = 1'b0;

    // Exception during DRAIN restarts the drain with the new target
    br_miss_i = 1'b1; br_target_i = 32'h1C00_0300;
    step();
    idle_inputs();
    excp_trigger_i = 1'b1; excp_target_i = 32'h1C00_A000;
    step();
    check("drain_excp_flush", {31'h0, flush_o}, 32'h1);
    check("drain_excp_cnt",   {16'h0, excp_cnt_o}, 32'h2);
    idle_inputs();
    step();
    check("drain_restart_valid", {31'h0, redirect_valid_o}, 32'h0);
    step();
    check("drain_excp_valid", {31'h0, redirect_valid_o}, 32'h1);
    check("drain_excp_pc",    redirect_pc_o, 32'h1C00_A000);

    // Reset while offering a redirect
    rst = 1'b1;
    step();
    check("rst_redir_valid", {31'h0, redirect_valid_o}, 32'h0);
    check("rst_redir_flush", {31'h0, flush_o}, 32'h0);
    check("rst_redir_busy",  {31'h0, busy_o}, 32'h0);
    check("rst_redir_pc",    redirect_pc_o, 32'h0);
    check("rst_redir_cnt",   {16'h0, excp_cnt_o}, 32'h0);
    rst = 1'b0;
    fe_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_valid", {31'h0, redirect_valid_o}, 32'h0);
    end

    // Exception counter wrap from a preloaded 0xFFFF
    #1;
    force dut.excp_cnt_r = 16'hFFFF;
    #1;
    release dut.excp_cnt_r;
    preload_now = 1'b1;
    step();
    preload_now = 1'b0;
    check("wrap_pre", {16'h0, excp_cnt_o}, 32'h0000_FFFF);
    excp_trigger_i = 1'b1; excp_target_i = 32'h1C00_C000;
    step();
    check("wrap_post", {16'h0, excp_cnt_o}, 32'h0);
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      excp_trigger_i = ($urandom_range(0, 11) == 0);
      excp_target_i  = $urandom;
      br_miss_i      = ($urandom_range(0, 3) == 0);
      br_target_i    = $urandom;
      fe_ready_i     = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
